// File: rtl/fmap_collector_pkg.sv
// fmap_collector_pkg: shared widths, frame geometry and FSM encoding for the feature-map collector
package fmap_collector_pkg;
  localparam int DEF_DIN_W     = 33;
  localparam int DEF_DOUT_W    = 16;
  localparam int DEF_SHIFT     = 8;
  localparam int DEF_FRAME_LEN = 676;
  localparam int DEF_ADDR_W    = 10;
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/fmap_collector_ram.sv
// fmap_collector_ram: simple dual-port RAM, one write port, registered read-first read port
module fmap_collector_ram #(
  parameter int DW = 16,
  parameter int AW = 10
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  // array stays unreset; only the output register clears so rd_data is 0 after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (re) q <= mem[ra];
endmodule

// File: rtl/fmap_collector.sv
// fmap_collector: captures one frame of conv results, requantizes to DOUT_W and serves them by random-access read
module fmap_collector
  import fmap_collector_pkg::*;
#(
  parameter int DIN_W     = DEF_DIN_W,
  parameter int DOUT_W    = DEF_DOUT_W,
  parameter int SHIFT     = DEF_SHIFT,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter bit RELU      = 1'b1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_flag,
  input  logic [DIN_W-1:0]  data_in,
  input  logic              in_valid,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DOUT_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              frame_done,
  output logic              buf_ready,
  output logic              overrun
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] LEN = ADDR_W'(FRAME_LEN);
  localparam logic signed [DIN_W-1:0] Q_MAX = DIN_W'(2**(DOUT_W-1) - 1);
  localparam logic signed [DIN_W-1:0] Q_MIN = -Q_MAX - 1;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] wr_cnt, q_addr;
  logic [DOUT_W-1:0] q_data, ram_q;
  logic q_valid, q_last, accept, drop, rd_oob, we;

  function automatic logic [DOUT_W-1:0] quantize(input logic [DIN_W-1:0] d);
    logic signed [DIN_W-1:0] s;
    s = $signed(d) >>> SHIFT;
    if (RELU && s < 0) s = '0;
    return s > Q_MAX ? Q_MAX[DOUT_W-1:0] : s < Q_MIN ? Q_MIN[DOUT_W-1:0] : s[DOUT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;

  always_comb
    state_nxt = start_flag ? COLLECT : (accept && wr_cnt == LAST) ? DONE : state;

  always_comb begin
    accept = in_valid && !start_flag && state == COLLECT;
    drop = in_valid && !start_flag && state != COLLECT;
  end

  // start_flag flushes the quantizer stage: its pending write and completion flag are dropped
  assign we = q_valid && !start_flag;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_cnt <= '0;
      q_valid <= 1'b0;
      q_last <= 1'b0;
      q_addr <= '0;
      q_data <= '0;
      frame_done <= 1'b0;
      buf_ready <= 1'b0;
      overrun <= 1'b0;
      rd_valid <= 1'b0;
      rd_oob <= 1'b0;
    end else begin
      wr_cnt <= start_flag ? '0 : accept ? wr_cnt + 1'b1 : wr_cnt;
      q_valid <= accept;
      q_last <= accept && wr_cnt == LAST;
      if (accept) q_addr <= wr_cnt;
      if (accept) q_data <= quantize(data_in);
      frame_done <= we && q_last;
      buf_ready <= !start_flag && (buf_ready || (q_valid && q_last));
      overrun <= !start_flag && (overrun || drop);
      rd_valid <= rd_en;
      if (rd_en) rd_oob <= rd_addr >= LEN;
    end

  assign rd_data = rd_oob ? '0 : ram_q;

  fmap_collector_ram #(.DW(DOUT_W), .AW(ADDR_W)) u_ram (
    .clk(clk), .rst_n(rst_n),
    .we(we), .wa(q_addr), .wd(q_data),
    .re(rd_en), .ra(rd_addr), .q(ram_q)
  );
endmodule

// File: tb/tb_fmap_collector.sv
// tb_fmap_collector: directed checks of capture, requantization, restart, reset and read port
module tb_fmap_collector;
  logic clk = 1'b0, rst_n, start_flag, in_valid, rd_en;
  logic [32:0] data_in;
  logic [9:0] rd_addr;
  logic signed [15:0] rd_data0, rd_data1;
  logic rd_valid0, rd_valid1, frame_done0, frame_done1, buf_ready0, buf_ready1, overrun0, overrun1;
  logic [32:0] qv [4];
  int checks = 0, errors = 0, fd;

  always #5 clk = ~clk;

  fmap_collector #(.RELU(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .start_flag(start_flag), .data_in(data_in), .in_valid(in_valid),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .frame_done(frame_done0), .buf_ready(buf_ready0), .overrun(overrun0)
  );
  fmap_collector #(.RELU(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .start_flag(start_flag), .data_in(data_in), .in_valid(in_valid),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .frame_done(frame_done1), .buf_ready(buf_ready1), .overrun(overrun1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start();
    start_flag = 1'b1;
    tick();
    start_flag = 1'b0;
  endtask

  task automatic rd(input string tag, input int a, input int e0, input int e1);
    rd_en = 1'b1;
    rd_addr = 10'(a);
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, rd_valid0, 1);
    chk({tag, "_relu"}, rd_data0, e0);
    chk({tag, "_norelu"}, rd_data1, e1);
    tick();
    chk({tag, "_valid_low"}, rd_valid0, 0);
    chk({tag, "_hold"}, rd_data0, e0);
  endtask

  task automatic send(input int n, input int base, input int step, input int ck, input int cold);
    fd = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      data_in = 33'(base + i * step) << 8;
      rd_en = ck >= 0 && i == ck + 1;
      rd_addr = 10'(ck);
      tick();
      fd += int'(frame_done0);
      if (ck >= 0 && i == ck + 1) begin
        chk("collide_valid", rd_valid0, 1);
        chk("collide_old", rd_data0, cold);
      end
    end
    in_valid = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic done_chk(input string tag);
    chk({tag, "_fd_t1"}, frame_done0, 0);
    chk({tag, "_rdy_t1"}, buf_ready0, 0);
    tick();
    chk({tag, "_fd_t2"}, frame_done0, 1);
    chk({tag, "_fd_t2_norelu"}, frame_done1, 1);
    chk({tag, "_rdy_t2"}, buf_ready0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start_flag = 1'b0;
    in_valid = 1'b0;
    rd_en = 1'b0;
    rd_addr = '0;
    data_in = '0;
    tick();
    tick();
    chk("rst_fd", frame_done0, 0);
    chk("rst_rdy", buf_ready0, 0);
    chk("rst_ovr", overrun0, 0);
    chk("rst_rdv", rd_valid0, 0);
    chk("rst_rdd", rd_data0, 0);
    rst_n = 1'b1;
    tick();
    // sample before any start
    in_valid = 1'b1;
    data_in = 33'(5) << 8;
    tick();
    in_valid = 1'b0;
    chk("ovr_prestart", overrun0, 1);
    chk("rdy_prestart", buf_ready0, 0);
    start();
    chk("ovr_cleared", overrun0, 0);
    // full frame of i<<8
    send(676, 0, 1, -1, 0);
    chk("f1_no_early_fd", fd, 0);
    done_chk("f1");
    tick();
    chk("f1_fd_pulse", frame_done0, 0);
    chk("f1_rdy_hold", buf_ready0, 1);
    rd("f1_a0", 0, 0, 0);
    rd("f1_a5", 5, 5, 5);
    rd("f1_a675", 675, 675, 675);
    rd("f1_a700", 700, 0, 0);
    // sample after DONE
    in_valid = 1'b1;
    data_in = 33'(999) << 8;
    tick();
    in_valid = 1'b0;
    chk("ovr_done", overrun0, 1);
    chk("rdy_after_ovr", buf_ready0, 1);
    rd("ovr_a0", 0, 0, 0);
    rd("ovr_a675", 675, 675, 675);
    // quantizer corners
    start();
    chk("q_ovr_clr", overrun0, 0);
    chk("q_rdy_clr", buf_ready0, 0);
    qv[0] = 33'h1_FFFF_FE00;
    qv[1] = 33'h0_8000_0000;
    qv[2] = 33'h1_0000_0000;
    qv[3] = 33'(100) << 8;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      data_in = qv[i];
      tick();
    end
    in_valid = 1'b0;
    tick();
    rd("q_neg512", 0, 0, -2);
    rd("q_pos2p31", 1, 32767, 32767);
    rd("q_neg2p32", 2, 0, -32768);
    rd("q_100", 3, 100, 100);
    // restart at sample 300, discarded coincident sample
    start();
    send(300, 1000, 1, -1, 0);
    chk("rs_no_fd_a", fd, 0);
    start_flag = 1'b1;
    in_valid = 1'b1;
    data_in = 33'(7777) << 8;
    tick();
    start_flag = 1'b0;
    in_valid = 1'b0;
    chk("rs_no_ovr", overrun0, 0);
    send(676, 2000, 1, -1, 0);
    chk("rs_no_fd_b", fd, 0);
    done_chk("rs");
    // back-to-back start while frame_done is high
    start();
    chk("b2b_rdy_clr", buf_ready0, 0);
    chk("b2b_fd_low", frame_done0, 0);
    rd("rs_a0", 0, 2000, 2000);
    rd("rs_a299", 299, 2299, 2299);
    rd("rs_a675", 675, 2675, 2675);
    // async reset mid-frame
    send(100, 0, 1, -1, 0);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fd", frame_done0, 0);
    chk("arst_rdy", buf_ready0, 0);
    chk("arst_ovr", overrun0, 0);
    chk("arst_rdv", rd_valid0, 0);
    chk("arst_rdd", rd_data0, 0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    start();
    send(676, 0, 3, 200, 2200);
    chk("ar_no_early_fd", fd, 0);
    done_chk("ar");
    rd("ar_a200", 200, 600, 600);
    rd("ar_a675", 675, 2025, 2025);
    rd("ar_a1", 1, 3, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
